hall_call_panel: RTL and testbench
==================================

# hall_call_panel

Hall-call side of the elevator system. The block latches up/down floor-button presses, ages each pending call, and offers one call at a time to the car controller over a valid/ready handshake. It clears calls when a car reports arrival at that floor in the matching direction. The controller's assignment consumes these offers, and the car's inc/dec arrival events feed back as clears.

## Interface
- FLOORS, 5, number of floors (0..FLOORS-1)
- FW, 3, floor-index width; FLOORS <= 2^FW
- AGE_W, 4, per-call age counter width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- up_press  in  FLOORS  hall up buttons, one bit per floor; bit FLOORS-1 ignored
- down_press  in  FLOORS  hall down buttons; bit 0 ignored
- arrive  in  1  one-cycle pulse: a car stopped with the door opening
- arrive_floor  in  FW  floor of the arrival
- arrive_dir  in  1  travel direction at arrival, 0=UP 1=DOWN
- req_ready  in  1  controller accepts the offered call this cycle
- req_valid  out  1  a call is offered
- req_floor  out  FW  floor of the offered call
- req_dir  out  1  direction of the offered call, 0=UP 1=DOWN
- up_lamp  out  FLOORS  up call pending (LIT or ACKED)
- down_lamp  out  FLOORS  down call pending
- any_above_mask, any_below_mask: not provided; the controller derives these from the lamps

## Operation
- There are 2*FLOORS-2 real calls. Each call has a state of OFF, LIT, or ACKED, plus a saturating age counter.
- OFF -> LIT when its press bit is 1. The age counter resets to 0 on this transition.
- A press on a LIT or ACKED call does nothing: no state change and no age reset.
- LIT -> ACKED when that call is the held offer and req_valid && req_ready is true at the clock edge.
- LIT or ACKED -> OFF when arrive=1, arrive_floor equals the call's floor, and arrive_dir equals the call's direction. The age counter is set to 0.
- When a clear and a press hit the same call in the same cycle, the clear wins and the call ends OFF.
- Arrival with arrive_floor >= FLOORS is ignored.
- Age increments by 1 every cycle while the call is LIT or ACKED, and saturates at 2^AGE_W-1.
- Offer selection applies only when no offer is held. Among LIT calls, pick the one with the highest age. Break ties by lowest floor, then UP before DOWN.
- Offer hold register (offer_v, offer_floor, offer_dir):
  - The register loads the selected call at a clock edge when offer_v=0 and some call is LIT.
  - It stays stable until the handshake completes. The selection is not re-evaluated while it is held.
  - offer_v drops on the handshake, or when an arrival clears the held call. A new selection may load no earlier than the following edge.
- req_valid = offer_v, req_floor = offer_floor, req_dir = offer_dir. These are direct register outputs.
- up_lamp[i] and down_lamp[i] are combinational from the call state (state != OFF). Lamps for nonexistent buttons are always 0.

## Timing
- Reset (asynchronous, while reset_n=0) sets:
  - all calls to OFF and all ages to 0;
  - offer_v=0, offer_floor=0, offer_dir=0;
  - all outputs to 0.
- Reset asserted mid-handshake drops req_valid immediately. There is no pending acceptance after release.
- Press at edge N gives a lamp high in cycle N+1. The earliest req_valid is at edge N+2, because the offer loads from LIT state.
- A handshake at edge M makes the call ACKED after M, with req_valid=0 in cycle M+1. The next offer can appear at edge M+1 and be visible in cycle M+2.
- Arrival at edge A turns the lamp off in cycle A+1. If the cleared call was the held offer, req_valid=0 in cycle A+1.
- If arrive and req_ready target the held call at the same edge, the call ends OFF.
- req_ready while req_valid=0 is ignored.

## Test plan
- Reset release, then press up_press[2] for 1 cycle -> up_lamp=00100 in the next cycle; req_valid=1, req_floor=2, req_dir=0 one cycle later; req_ready=1 -> req_valid=0 and up_lamp[2] stays 1 (ACKED).
- Simultaneous down_press[3] and up_press[1], equal age -> first offer is floor 1 UP. After its handshake, the next offer is floor 3 DOWN.
- Press up[0], wait 6 cycles holding req_ready=0 while pressing up[4] and down[2] -> req_floor holds at 0 throughout. With FLOORS=5, up[4] is ignored and up_lamp[4] stays 0.
- Call up[2] LIT and offered; arrive=1, floor 2, UP -> up_lamp[2]=0 and req_valid=0 the next cycle. Repeat with arrive_dir=DOWN -> no change.
- Same-cycle up_press[2] and arrive on floor 2 UP -> up_lamp[2]=0 and no offer. Same-cycle req_ready and arrival on the held call -> call OFF.
- Hold a call LIT for 20 cycles with AGE_W=4 -> age saturates at 15 without wrap. Pulse reset_n low mid-offer -> req_valid and all lamps go 0 asynchronously.

Source files
------------

// File: rtl/hall_call_panel.sv
// rtl/hall_call_panel.sv - hall-call latch, ageing and single-offer handshake to the car controller
module hall_call_panel #(
    parameter int FLOORS = 5,
    parameter int FW     = 3,
    parameter int AGE_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FLOORS-1:0] up_press,
    input  logic [FLOORS-1:0] down_press,
    input  logic              arrive,
    input  logic [FW-1:0]     arrive_floor,
    input  logic              arrive_dir,
    input  logic              req_ready,
    output logic              req_valid,
    output logic [FW-1:0]     req_floor,
    output logic              req_dir,
    output logic [FLOORS-1:0] up_lamp,
    output logic [FLOORS-1:0] down_lamp
);

    typedef enum logic [1:0] {
        C_OFF   = 2'd0,
        C_LIT   = 2'd1,
        C_ACKED = 2'd2
    } call_t;

    // The top floor has no up button and the ground floor has no down button.
    localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};
    localparam logic [FW:0]       FLOORS_W = (FW+1)'(FLOORS);

    call_t            up_st  [FLOORS];
    call_t            dn_st  [FLOORS];
    logic [AGE_W-1:0] up_age [FLOORS];
    logic [AGE_W-1:0] dn_age [FLOORS];

    logic              offer_v;
    logic [FW-1:0]     offer_floor;
    logic              offer_dir;

    logic [FLOORS-1:0] up_req;
    logic [FLOORS-1:0] dn_req;
    logic [FLOORS-1:0] up_clr;
    logic [FLOORS-1:0] dn_clr;
    logic              arrive_ok;
    logic              handshake;
    logic              held_clr;

    logic              sel_v;
    logic [FW-1:0]     sel_floor;
    logic              sel_dir;
    logic [AGE_W-1:0]  best_age;

    // Decode presses, arrival clears and the handshake for this cycle.
    always_comb begin
        up_req    = up_press & UP_MASK;
        dn_req    = down_press & DN_MASK;
        arrive_ok = arrive && ({1'b0, arrive_floor} < FLOORS_W);
        for (int i = 0; i < FLOORS; i++) begin
            up_clr[i] = arrive_ok && (arrive_floor == FW'(i)) && !arrive_dir;
            dn_clr[i] = arrive_ok && (arrive_floor == FW'(i)) &&  arrive_dir;
        end
        handshake = offer_v && req_ready;
        held_clr  = offer_v && arrive_ok && (arrive_floor == offer_floor) && (arrive_dir == offer_dir);
    end

    // Pick the oldest LIT call; scanning low floor first, UP before DOWN, with a strict
    // greater-than keeps the earliest candidate on ties. A call being cleared now is skipped.
    always_comb begin
        sel_v     = 1'b0;
        sel_floor = '0;
        sel_dir   = 1'b0;
        best_age  = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (up_st[i] == C_LIT && !up_clr[i] && (!sel_v || up_age[i] > best_age)) begin
                sel_v     = 1'b1;
                best_age  = up_age[i];
                sel_floor = FW'(i);
                sel_dir   = 1'b0;
            end
            if (dn_st[i] == C_LIT && !dn_clr[i] && (!sel_v || dn_age[i] > best_age)) begin
                sel_v     = 1'b1;
                best_age  = dn_age[i];
                sel_floor = FW'(i);
                sel_dir   = 1'b1;
            end
        end
    end

    // Up-call state machines and saturating ages; an arrival clear beats both press and ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FLOORS; i++) begin
                up_st[i]  <= C_OFF;
                up_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FLOORS; i++) begin
                if (up_clr[i]) begin
                    up_st[i]  <= C_OFF;
                    up_age[i] <= '0;
                end else begin
                    case (up_st[i])
                        C_OFF: begin
                            if (up_req[i]) begin
                                up_st[i]  <= C_LIT;
                                up_age[i] <= '0;
                            end
                        end
                        C_LIT: begin
                            if (handshake && offer_floor == FW'(i) && !offer_dir)
                                up_st[i] <= C_ACKED;
                            if (up_age[i] != '1)
                                up_age[i] <= up_age[i] + 1'b1;
                        end
                        default: begin
                            if (up_age[i] != '1)
                                up_age[i] <= up_age[i] + 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Down-call state machines and saturating ages, mirroring the up side.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FLOORS; i++) begin
                dn_st[i]  <= C_OFF;
                dn_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FLOORS; i++) begin
                if (dn_clr[i]) begin
                    dn_st[i]  <= C_OFF;
                    dn_age[i] <= '0;
                end else begin
                    case (dn_st[i])
                        C_OFF: begin
                            if (dn_req[i]) begin
                                dn_st[i]  <= C_LIT;
                                dn_age[i] <= '0;
                            end
                        end
                        C_LIT: begin
                            if (handshake && offer_floor == FW'(i) && offer_dir)
                                dn_st[i] <= C_ACKED;
                            if (dn_age[i] != '1)
                                dn_age[i] <= dn_age[i] + 1'b1;
                        end
                        default: begin
                            if (dn_age[i] != '1)
                                dn_age[i] <= dn_age[i] + 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Offer hold register: frozen while valid, dropped on handshake or clear, reloaded a cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            offer_v     <= 1'b0;
            offer_floor <= '0;
            offer_dir   <= 1'b0;
        end else if (offer_v) begin
            if (handshake || held_clr)
                offer_v <= 1'b0;
        end else if (sel_v) begin
            offer_v     <= 1'b1;
            offer_floor <= sel_floor;
            offer_dir   <= sel_dir;
        end
    end

    // Lamps show any pending call; nonexistent buttons never leave OFF.
    always_comb begin
        for (int i = 0; i < FLOORS; i++) begin
            up_lamp[i]   = UP_MASK[i] && (up_st[i] != C_OFF);
            down_lamp[i] = DN_MASK[i] && (dn_st[i] != C_OFF);
        end
    end

    assign req_valid = offer_v;
    assign req_floor = offer_floor;
    assign req_dir   = offer_dir;

endmodule

// File: tb/tb_hall_call_panel.sv
// tb/tb_hall_call_panel.sv - scoreboard bench for hall_call_panel
module tb_hall_call_panel;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] up_press = '0;
    logic [4:0] down_press = '0;
    logic       arrive = 1'b0;
    logic [2:0] arrive_floor = '0;
    logic       arrive_dir = 1'b0;
    logic       req_ready = 1'b0;
    logic       req_valid;
    logic [2:0] req_floor;
    logic       req_dir;
    logic [4:0] up_lamp;
    logic [4:0] down_lamp;

    typedef struct packed {
        logic [2:0] floor;
        logic       dir;
    } offer_t;

    offer_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    hall_call_panel #(.FLOORS(5), .FW(3), .AGE_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .up_press     (up_press),
        .down_press   (down_press),
        .arrive       (arrive),
        .arrive_floor (arrive_floor),
        .arrive_dir   (arrive_dir),
        .req_ready    (req_ready),
        .req_valid    (req_valid),
        .req_floor    (req_floor),
        .req_dir      (req_dir),
        .up_lamp      (up_lamp),
        .down_lamp    (down_lamp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] up, input logic [4:0] dn);
        up_press   = up;
        down_press = dn;
        tick();
        up_press   = '0;
        down_press = '0;
    endtask

    task automatic do_arrive(input logic [2:0] fl, input logic dir);
        arrive       = 1'b1;
        arrive_floor = fl;
        arrive_dir   = dir;
        tick();
        arrive       = 1'b0;
    endtask

    task automatic accept_offer(input string name);
        int     waited;
        offer_t e;
        waited = 0;
        while (req_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (req_valid !== 1'b1 || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_offer: req_valid=%b queued=%0d required valid offer with queued entry", name, req_valid, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({req_floor, req_dir} !== {e.floor, e.dir}) begin
            n_fail++;
            $display("FAIL %s_sel: floor=%0d dir=%b required floor=%0d dir=%b", name, req_floor, req_dir, e.floor, e.dir);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        n_checks++;
        if (req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drop: req_valid=%b required 0", name, req_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({req_valid, req_floor, req_dir, up_lamp, down_lamp} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {req_valid, req_floor, req_dir, up_lamp, down_lamp});
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        press(5'b00100, 5'b00000);
        n_checks++;
        if (up_lamp !== 5'b00100 || req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_lamp: up_lamp=%b req_valid=%b required 00100 0", up_lamp, req_valid);
        end
        tick();
        n_checks++;
        if (req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: req_valid=%b required 1", req_valid);
        end
        exp_q.push_back('{floor: 3'd2, dir: 1'b0});
        accept_offer("basic");
        n_checks++;
        if (up_lamp !== 5'b00100) begin
            n_fail++;
            $display("FAIL basic_acked_lamp: up_lamp=%b required 00100", up_lamp);
        end
        do_arrive(3'd2, 1'b0);
        n_checks++;
        if (up_lamp !== 5'b00000) begin
            n_fail++;
            $display("FAIL basic_clear: up_lamp=%b required 00000", up_lamp);
        end
    endtask

    task automatic test_tie_break();
        press(5'b00010, 5'b01000);
        exp_q.push_back('{floor: 3'd1, dir: 1'b0});
        exp_q.push_back('{floor: 3'd3, dir: 1'b1});
        accept_offer("tie_first");
        accept_offer("tie_second");
        do_arrive(3'd1, 1'b0);
        do_arrive(3'd3, 1'b1);
        n_checks++;
        if (up_lamp !== 5'b0 || down_lamp !== 5'b0) begin
            n_fail++;
            $display("FAIL tie_cleanup: up=%b down=%b required 0 0", up_lamp, down_lamp);
        end
    endtask

    task automatic test_hold();
        press(5'b00001, 5'b00000);
        tick();
        for (int k = 0; k < 6; k++) begin
            up_press   = 5'b10000;
            down_press = 5'b00100;
            tick();
            n_checks++;
            if (req_valid !== 1'b1 || req_floor !== 3'd0 || up_lamp[4] !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b floor=%0d up_lamp4=%b required 1 0 0", k, req_valid, req_floor, up_lamp[4]);
            end
        end
        up_press   = '0;
        down_press = '0;
        n_checks++;
        if (down_lamp !== 5'b00100) begin
            n_fail++;
            $display("FAIL hold_down_lamp: down_lamp=%b required 00100", down_lamp);
        end
        exp_q.push_back('{floor: 3'd0, dir: 1'b0});
        exp_q.push_back('{floor: 3'd2, dir: 1'b1});
        accept_offer("hold_first");
        accept_offer("hold_second");
        do_arrive(3'd0, 1'b0);
        do_arrive(3'd2, 1'b1);
    endtask

    task automatic test_arrive_clear();
        press(5'b00100, 5'b00000);
        tick();
        do_arrive(3'd2, 1'b1);
        n_checks++;
        if (up_lamp !== 5'b00100 || req_valid !== 1'b1 || req_floor !== 3'd2) begin
            n_fail++;
            $display("FAIL arrive_wrong_dir: up=%b valid=%b floor=%0d required 00100 1 2", up_lamp, req_valid, req_floor);
        end
        do_arrive(3'd2, 1'b0);
        n_checks++;
        if (up_lamp !== 5'b00000 || req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arrive_clear: up=%b valid=%b required 00000 0", up_lamp, req_valid);
        end
    endtask

    task automatic test_same_cycle();
        up_press     = 5'b00100;
        arrive       = 1'b1;
        arrive_floor = 3'd2;
        arrive_dir   = 1'b0;
        tick();
        up_press = '0;
        arrive   = 1'b0;
        tick();
        n_checks++;
        if (up_lamp !== 5'b0 || req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL press_vs_clear: up=%b valid=%b required 00000 0", up_lamp, req_valid);
        end
        press(5'b01000, 5'b00000);
        tick();
        n_checks++;
        if (req_valid !== 1'b1 || req_floor !== 3'd3) begin
            n_fail++;
            $display("FAIL ack_vs_clear_offer: valid=%b floor=%0d required 1 3", req_valid, req_floor);
        end
        req_ready    = 1'b1;
        arrive       = 1'b1;
        arrive_floor = 3'd3;
        arrive_dir   = 1'b0;
        tick();
        req_ready = 1'b0;
        arrive    = 1'b0;
        tick();
        n_checks++;
        if (up_lamp !== 5'b0 || req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_vs_clear: up=%b valid=%b required 00000 0", up_lamp, req_valid);
        end
    endtask

    task automatic test_age_saturation();
        press(5'b00010, 5'b00000);
        tick();
        press(5'b00000, 5'b01000);
        repeat (3) tick();
        press(5'b00100, 5'b00000);
        repeat (25) tick();
        n_checks++;
        if (up_lamp !== 5'b00110 || down_lamp !== 5'b01000 || req_floor !== 3'd1) begin
            n_fail++;
            $display("FAIL age_setup: up=%b down=%b floor=%0d required 00110 01000 1", up_lamp, down_lamp, req_floor);
        end
        exp_q.push_back('{floor: 3'd1, dir: 1'b0});
        exp_q.push_back('{floor: 3'd2, dir: 1'b0});
        exp_q.push_back('{floor: 3'd3, dir: 1'b1});
        accept_offer("age_first");
        accept_offer("age_saturated_tie");
        accept_offer("age_last");
        do_arrive(3'd1, 1'b0);
        do_arrive(3'd2, 1'b0);
        do_arrive(3'd3, 1'b1);
        n_checks++;
        if (up_lamp !== 5'b0 || down_lamp !== 5'b0) begin
            n_fail++;
            $display("FAIL age_cleanup: up=%b down=%b required 0 0", up_lamp, down_lamp);
        end
    endtask

    task automatic test_async_reset();
        press(5'b00000, 5'b00010);
        tick();
        n_checks++;
        if (req_valid !== 1'b1 || req_floor !== 3'd1 || req_dir !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_offer: valid=%b floor=%0d dir=%b required 1 1 1", req_valid, req_floor, req_dir);
        end
        #2;
        reset_n   = 1'b0;
        req_ready = 1'b1;
        #1;
        n_checks++;
        if ({req_valid, req_floor, req_dir, up_lamp, down_lamp} !== 15'd0) begin
            n_fail++;
            $display("FAIL areset_async: got %b required 0", {req_valid, req_floor, req_dir, up_lamp, down_lamp});
        end
        tick();
        reset_n = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        n_checks++;
        if ({req_valid, up_lamp, down_lamp} !== 11'd0) begin
            n_fail++;
            $display("FAIL areset_release: got %b required 0", {req_valid, up_lamp, down_lamp});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_break();
        test_hold();
        test_arrive_clear();
        test_same_cycle();
        test_age_saturation();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
